// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared command/response codes and per-port FSM encoding
// Purpose: constants and types shared by the calc request sequencer and its FIFO.
// Ports: none (package).
package calc_pkg;

  localparam int unsigned CMD_NOP = 0;
  localparam int unsigned CMD_ADD = 1;
  localparam int unsigned CMD_SUB = 2;
  localparam int unsigned CMD_LSH = 5;
  localparam int unsigned CMD_RSH = 6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } port_state_t;

endpackage

// File: rtl/calc_req_fifo.sv
// rtl/calc_req_fifo.sv - synchronous show-ahead FIFO holding queued calc operations
// Purpose: per-port operation queue; head entry is visible on o_rd_data while not empty.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (empties the queue)
//   i_wr_en, i_wr_data  write request and entry; ignored while full
//   i_rd_en             pop the head entry; ignored while empty
//   o_rd_data           current head entry
//   o_full, o_empty     occupancy flags
module calc_req_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full (wrapped) from empty (equal).
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr_en && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (i_rd_en && !o_empty) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/calc_req_sequencer.sv
// rtl/calc_req_sequencer.sv - multi-port calc request sequencer with per-port FIFOs
// Purpose: queues operations per DUT port, drives the two-cycle request protocol,
//   waits for a response or timeout, and reports completions on one result stream.
// Ports:
//   c_clk, reset                 clock, synchronous active-high reset
//   push_*                       operation enqueue interface (push_ready combinational)
//   req_cmd_out, req_data_out    per-port request pins to the DUT (packed by port)
//   out_resp, out_data           per-port DUT response pins (packed by port)
//   result_*                     registered one-cycle completion report
//   spurious_resp                sticky per-port flag: response seen outside WAIT
module calc_req_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           c_clk,
  input  logic                           reset,
  input  logic                           push_valid,
  output logic                           push_ready,
  input  logic [$clog2(NUM_PORTS)-1:0]   push_port,
  input  logic [CMD_W-1:0]               push_cmd,
  input  logic [DATA_W-1:0]              push_op1,
  input  logic [DATA_W-1:0]              push_op2,
  output logic [NUM_PORTS*CMD_W-1:0]     req_cmd_out,
  output logic [NUM_PORTS*DATA_W-1:0]    req_data_out,
  input  logic [NUM_PORTS*2-1:0]         out_resp,
  input  logic [NUM_PORTS*DATA_W-1:0]    out_data,
  output logic                           result_valid,
  output logic [$clog2(NUM_PORTS)-1:0]   result_port,
  output logic [1:0]                     result_resp,
  output logic [DATA_W-1:0]              result_data,
  output logic                           result_timeout,
  output logic [NUM_PORTS-1:0]           spurious_resp
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int NP2 = 1 << PW;
  localparam int EW  = CMD_W + 2*DATA_W;
  localparam int TW  = $clog2(TIMEOUT);

  // Port-indexed lookups padded to the full push_port range so that an
  // out-of-range port reads as "not a port" and "full".
  logic [NP2-1:0]       w_port_ok;
  logic [NP2-1:0]       w_full_pad;

  logic [NUM_PORTS-1:0] w_done;
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] w_cap_tmo;
  logic [1:0]           w_cap_resp [NUM_PORTS];
  logic [DATA_W-1:0]    w_cap_data [NUM_PORTS];
  logic                 w_any_done;
  logic [PW-1:0]        w_sel;

  assign push_ready = w_port_ok[push_port] & ~w_full_pad[push_port];

  for (genvar k = NUM_PORTS; k < NP2; k++) begin : g_pad
    assign w_port_ok[k]  = 1'b0;
    assign w_full_pad[k] = 1'b1;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    port_state_t       r_state, w_state_nx;
    logic [CMD_W-1:0]  r_cmd, w_cmd_nx;
    logic [DATA_W-1:0] r_dout, w_dout_nx;
    logic [DATA_W-1:0] r_op2, w_op2_nx;
    logic [DATA_W-1:0] r_cap_data, w_cap_data_nx;
    logic [1:0]        r_cap_resp, w_cap_resp_nx;
    logic              r_cap_tmo, w_cap_tmo_nx;
    logic [TW-1:0]     r_timer, w_timer_nx;
    logic              r_spur;
    logic              w_wr_en, w_pop, w_full, w_empty;
    logic [EW-1:0]     w_head;
    logic [1:0]        w_resp_in;
    logic [DATA_W-1:0] w_data_in;

    assign w_resp_in = out_resp[g*2 +: 2];
    assign w_data_in = out_data[g*DATA_W +: DATA_W];
    assign w_wr_en   = push_valid && push_ready && (push_port == PW'(g));

    calc_req_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk     (c_clk),
      .i_reset   (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_data ({push_cmd, push_op1, push_op2}),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
    );

    always_comb begin
      w_state_nx    = r_state;
      w_cmd_nx      = r_cmd;
      w_dout_nx     = r_dout;
      w_op2_nx      = r_op2;
      w_cap_data_nx = r_cap_data;
      w_cap_resp_nx = r_cap_resp;
      w_cap_tmo_nx  = r_cap_tmo;
      w_timer_nx    = r_timer;
      w_pop         = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_cmd_nx   = w_head[EW-1 -: CMD_W];
            w_dout_nx  = w_head[2*DATA_W-1 -: DATA_W];
            w_op2_nx   = w_head[DATA_W-1:0];
            w_state_nx = ST_OP1;
          end
        end
        ST_OP1: begin
          w_cmd_nx   = CMD_W'(CMD_NOP);
          w_dout_nx  = r_op2;
          w_state_nx = ST_OP2;
        end
        ST_OP2: begin
          w_cmd_nx   = CMD_W'(CMD_NOP);
          w_dout_nx  = '0;
          w_timer_nx = '0;
          w_state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          // A response wins over a timer expiring in the same cycle.
          if (w_resp_in != RESP_NONE) begin
            w_cap_resp_nx = w_resp_in;
            w_cap_data_nx = w_data_in;
            w_cap_tmo_nx  = 1'b0;
            w_state_nx    = ST_DONE;
          end else if (r_timer == TW'(TIMEOUT-1)) begin
            w_cap_resp_nx = RESP_NONE;
            w_cap_data_nx = '0;
            w_cap_tmo_nx  = 1'b1;
            w_state_nx    = ST_DONE;
          end else begin
            w_timer_nx = r_timer + TW'(1);
          end
        end
        ST_DONE: begin
          if (w_grant[g]) begin
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        r_state    <= ST_IDLE;
        r_cmd      <= '0;
        r_dout     <= '0;
        r_op2      <= '0;
        r_cap_data <= '0;
        r_cap_resp <= '0;
        r_cap_tmo  <= 1'b0;
        r_timer    <= '0;
        r_spur     <= 1'b0;
      end else begin
        r_state    <= w_state_nx;
        r_cmd      <= w_cmd_nx;
        r_dout     <= w_dout_nx;
        r_op2      <= w_op2_nx;
        r_cap_data <= w_cap_data_nx;
        r_cap_resp <= w_cap_resp_nx;
        r_cap_tmo  <= w_cap_tmo_nx;
        r_timer    <= w_timer_nx;
        if ((r_state != ST_WAIT) && (w_resp_in != RESP_NONE)) begin
          r_spur <= 1'b1;
        end
      end
    end

    assign w_port_ok[g]                      = 1'b1;
    assign w_full_pad[g]                     = w_full;
    assign w_done[g]                         = (r_state == ST_DONE);
    assign w_cap_resp[g]                     = r_cap_resp;
    assign w_cap_data[g]                     = r_cap_data;
    assign w_cap_tmo[g]                      = r_cap_tmo;
    assign req_cmd_out[g*CMD_W +: CMD_W]     = r_cmd;
    assign req_data_out[g*DATA_W +: DATA_W]  = r_dout;
    assign spurious_resp[g]                  = r_spur;
  end

  // Lowest-index DONE port wins; isolate its bit for the per-port release.
  assign w_any_done = |w_done;
  assign w_grant    = w_done & (~w_done + NUM_PORTS'(1));

  always_comb begin
    w_sel = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (w_done[i]) begin
        w_sel = PW'(i);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      result_valid   <= 1'b0;
      result_port    <= '0;
      result_resp    <= '0;
      result_data    <= '0;
      result_timeout <= 1'b0;
    end else begin
      result_valid <= w_any_done;
      if (w_any_done) begin
        result_port    <= w_sel;
        result_resp    <= w_cap_resp[w_sel];
        result_data    <= w_cap_data[w_sel];
        result_timeout <= w_cap_tmo[w_sel];
      end else begin
        result_port    <= '0;
        result_resp    <= '0;
        result_data    <= '0;
        result_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_req_sequencer.sv
// tb/tb_calc_req_sequencer.sv - self-checking bench for calc_req_sequencer
module tb_calc_req_sequencer;
  import calc_pkg::*;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          delay;
    bit          silent;
    logic [1:0]  resp;
    logic [31:0] data;
    bit          tmo;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    bit          tmo;
  } res_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } iss_t;

  logic              c_clk = 1'b0;
  logic              reset = 1'b1;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [1:0]        push_port = '0;
  logic [CW-1:0]     push_cmd = '0;
  logic [DW-1:0]     push_op1 = '0;
  logic [DW-1:0]     push_op2 = '0;
  logic [NP*CW-1:0]  req_cmd_out;
  logic [NP*DW-1:0]  req_data_out;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic              result_valid;
  logic [1:0]        result_port;
  logic [1:0]        result_resp;
  logic [DW-1:0]     result_data;
  logic              result_timeout;
  logic [NP-1:0]     spurious_resp;

  logic [NP*2-1:0]   m_resp = '0;
  logic [NP*DW-1:0]  m_data = '0;
  logic [NP*2-1:0]   man_resp = '0;
  logic [NP*DW-1:0]  man_data = '0;
  assign out_resp = m_resp | man_resp;
  assign out_data = m_data | man_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          m_ph [NP];
  int          m_cnt [NP];
  int          m_delay [NP];
  int          m_wait_cyc [NP];
  int          r_cyc [NP];
  bit          m_silent [NP];
  logic [3:0]  m_cmd [NP];
  logic [31:0] m_op1 [NP];
  logic [31:0] m_op2 [NP];
  bit          lat_skip = 1'b0;

  res_t sb [NP][$];
  iss_t iq [NP][$];

  calc_req_sequencer #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .CMD_W     (CW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .c_clk          (c_clk),
    .reset          (reset),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_port      (push_port),
    .push_cmd       (push_cmd),
    .push_op1       (push_op1),
    .push_op2       (push_op2),
    .req_cmd_out    (req_cmd_out),
    .req_data_out   (req_data_out),
    .out_resp       (out_resp),
    .out_data       (out_data),
    .result_valid   (result_valid),
    .result_port    (result_port),
    .result_resp    (result_resp),
    .result_data    (result_data),
    .result_timeout (result_timeout),
    .spurious_resp  (spurious_resp)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] dut_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'(CMD_ADD): return {RESP_OK, a + b};
      4'(CMD_SUB): return {RESP_OK, a - b};
      4'(CMD_LSH): return {RESP_OK, a << b};
      4'(CMD_RSH): return {RESP_OK, a >> b};
      default:     return {RESP_ERR, 32'h0};
    endcase
  endfunction

  // DUT model: follows the request protocol on each port, checks the issued
  // sequence against the push order, then answers after m_delay cycles.
  always @(negedge c_clk) begin
    for (int p = 0; p < NP; p++) begin
      logic [3:0]  c;
      logic [31:0] d;
      iss_t        e;
      c = req_cmd_out[p*CW +: CW];
      d = req_data_out[p*DW +: DW];
      if (reset) begin
        m_ph[p] = 0;
        m_resp[p*2 +: 2] = 2'd0;
      end else begin
        case (m_ph[p])
          0: if (c != 4'd0) begin
               if (iq[p].size() == 0) begin
                 chk("issue_unexpected_cmd", c, 0);
               end else begin
                 e = iq[p].pop_front();
                 chk("issue_cmd", c, e.cmd);
                 chk("issue_op1", d, e.op1);
               end
               m_cmd[p] = c;
               m_op1[p] = d;
               m_ph[p]  = 1;
             end
          1: begin
               chk("op2_phase_cmd", c, 0);
               m_op2[p] = d;
               m_ph[p]  = 2;
             end
          2: begin
               chk("tail_phase_cmd", c, 0);
               chk("tail_phase_data", d, 0);
               m_wait_cyc[p] = cyc;
               if (m_silent[p]) begin
                 m_ph[p] = 0;
               end else if (m_delay[p] == 0) begin
                 {m_resp[p*2 +: 2], m_data[p*DW +: DW]} = dut_calc(m_cmd[p], m_op1[p], m_op2[p]);
                 m_ph[p] = 5;
               end else begin
                 m_cnt[p] = 1;
                 m_ph[p]  = 3;
               end
             end
          3: if (m_cnt[p] == m_delay[p]) begin
               {m_resp[p*2 +: 2], m_data[p*DW +: DW]} = dut_calc(m_cmd[p], m_op1[p], m_op2[p]);
               m_ph[p] = 5;
             end else begin
               m_cnt[p] = m_cnt[p] + 1;
             end
          5: begin
               m_resp[p*2 +: 2] = 2'd0;
               m_ph[p] = 0;
             end
          default: m_ph[p] = 0;
        endcase
      end
    end
  end

  // Result monitor: pops the per-port scoreboard on every completion pulse.
  always @(negedge c_clk) begin
    int   p;
    res_t r;
    if (!reset && result_valid) begin
      p = int'(result_port);
      r_cyc[p] = cyc;
      if (sb[p].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: port %0d reported with nothing pending", p);
      end else begin
        r = sb[p].pop_front();
        chk("result_resp", result_resp, r.resp);
        chk("result_data", result_data, r.data);
        chk("result_timeout", result_timeout, r.tmo);
        if (!lat_skip)
          chk("result_latency", cyc - m_wait_cyc[p], r.tmo ? TMO + 1 : m_delay[p] + 2);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic push(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int waited);
    push_valid = 1'b1;
    push_port  = 2'(p);
    push_cmd   = c;
    push_op1   = a;
    push_op2   = b;
    waited     = 0;
    #1;
    while (!push_ready && waited < 400) begin
      tick(1);
      waited++;
    end
    if (!push_ready) begin
      total++;
      bad++;
      $display("FAIL push_bound: port %0d never became ready", p);
      push_valid = 1'b0;
    end else begin
      iq[p].push_back('{c, a, b});
      tick(1);
      push_valid = 1'b0;
    end
  endtask

  task automatic expect_res(input int p, input logic [1:0] r, input logic [31:0] d, input bit t);
    sb[p].push_back('{r, d, t});
  endtask

  task automatic wait_drain(input int p);
    int n;
    n = 0;
    while (sb[p].size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    chk("drain_pending", sb[p].size(), 0);
    tick(3);
  endtask

  initial begin
    vec_t vt [6];
    int   w;
    int   n;

    vt[0] = '{1, 4'(CMD_SUB), 32'h0000_0010, 32'h0000_0020, 0, 1'b0, RESP_OK,  32'hFFFF_FFF0, 1'b0};
    vt[1] = '{3, 4'(CMD_RSH), 32'h8000_0000, 32'd31,        4, 1'b0, RESP_OK,  32'h0000_0001, 1'b0};
    vt[2] = '{0, 4'(CMD_ADD), 32'hFFFF_FFFF, 32'h0000_0001, 1, 1'b0, RESP_OK,  32'h0000_0000, 1'b0};
    vt[3] = '{2, 4'(CMD_LSH), 32'h0000_0003, 32'd8,         2, 1'b0, RESP_OK,  32'h0000_0300, 1'b0};
    vt[4] = '{0, 4'd7,        32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, RESP_ERR, 32'h0000_0000, 1'b0};
    vt[5] = '{1, 4'(CMD_ADD), 32'h0000_0005, 32'h0000_0006, 0, 1'b1, RESP_NONE, 32'h0000_0000, 1'b1};

    for (int p = 0; p < NP; p++) begin
      m_ph[p] = 0; m_cnt[p] = 0; m_delay[p] = 0; m_silent[p] = 1'b0;
      m_wait_cyc[p] = 0; r_cyc[p] = 0;
    end

    // Reset with garbage on the response pins.
    reset    = 1'b1;
    man_resp = 8'hA5;
    man_data = '1;
    tick(2);
    chk("rst_req_cmd", req_cmd_out, 0);
    chk("rst_req_data", req_data_out, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_port", result_port, 0);
    chk("rst_result_resp", result_resp, 0);
    chk("rst_result_data", result_data, 0);
    chk("rst_result_timeout", result_timeout, 0);
    chk("rst_spurious", spurious_resp, 0);
    for (int p = 0; p < NP; p++) begin
      push_port = 2'(p);
      #1;
      chk("rst_push_ready", push_ready, 1);
    end
    man_resp = '0;
    man_data = '0;
    reset    = 1'b0;
    tick(1);

    // Port 0 ADD with hand-checked request timing.
    m_delay[0] = 2;
    push(0, 4'(CMD_ADD), 32'hFFFF_0000, 32'h0000_FFFF, w);
    expect_res(0, RESP_OK, 32'hFFFF_FFFF, 1'b0);
    tick(1);
    chk("add_cmd_e1", req_cmd_out[3:0], 1);
    chk("add_data_e1", req_data_out[31:0], 32'hFFFF_0000);
    tick(1);
    chk("add_cmd_e2", req_cmd_out[3:0], 0);
    chk("add_data_e2", req_data_out[31:0], 32'h0000_FFFF);
    tick(1);
    chk("add_cmd_e3", req_cmd_out[3:0], 0);
    chk("add_data_e3", req_data_out[31:0], 0);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!result_valid && n < 50);
    chk("add_result_edges", n, 4);
    chk("add_result_port", result_port, 0);
    tick(1);
    chk("add_single_pulse", result_valid, 0);
    wait_drain(0);

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      m_delay[vt[i].port]  = vt[i].delay;
      m_silent[vt[i].port] = vt[i].silent;
      push(vt[i].port, vt[i].cmd, vt[i].op1, vt[i].op2, w);
      expect_res(vt[i].port, vt[i].resp, vt[i].data, vt[i].tmo);
      wait_drain(vt[i].port);
    end
    m_silent[1] = 1'b0;
    chk("no_spurious_after_table", spurious_resp, 0);

    // Port 2 silent: fill the FIFO behind an in-flight op, then a stalled push.
    m_silent[2] = 1'b1;
    push(2, 4'(CMD_ADD), 32'd100, 32'd0, w);
    expect_res(2, RESP_NONE, 32'h0, 1'b1);
    tick(5);
    for (int k = 0; k < DEPTH; k++) begin
      push(2, 4'(CMD_ADD), 32'd101 + 32'(k), 32'd0, w);
      expect_res(2, RESP_NONE, 32'h0, 1'b1);
    end
    push_port = 2'd2;
    #1;
    chk("p2_full_not_ready", push_ready, 0);
    push_port = 2'd0;
    #1;
    chk("p0_ready_while_p2_full", push_ready, 1);
    push_port  = 2'd2;
    push_cmd   = 4'(CMD_SUB);
    push_op1   = 32'hBAD0_BAD0;
    push_valid = 1'b1;
    tick(1);
    push_valid = 1'b0;
    push(2, 4'(CMD_ADD), 32'd105, 32'd0, w);
    expect_res(2, RESP_NONE, 32'h0, 1'b1);
    chk("p2_push_stalled", (w > 0), 1);
    wait_drain(2);

    // Ports 1 and 3 answer in the same cycle; port 1 reports first.
    lat_skip   = 1'b1;
    m_delay[1] = 1;
    m_delay[3] = 0;
    push(1, 4'(CMD_SUB), 32'h9999_9999, 32'h5555_5555, w);
    expect_res(1, RESP_OK, 32'h4444_4444, 1'b0);
    push(3, 4'(CMD_LSH), 32'h0000_0001, 32'd4, w);
    expect_res(3, RESP_OK, 32'h0000_0010, 1'b0);
    wait_drain(1);
    wait_drain(3);
    chk("p3_one_after_p1", r_cyc[3] - r_cyc[1], 1);
    lat_skip = 1'b0;

    // Spurious response on idle port 2.
    chk("spurious_clear_before", spurious_resp, 0);
    man_resp[5:4] = RESP_OK;
    tick(1);
    man_resp[5:4] = RESP_NONE;
    tick(1);
    chk("spurious_set_p2", spurious_resp, 4'b0100);
    tick(5);
    chk("spurious_sticky_p2", spurious_resp, 4'b0100);

    // Reset during WAIT on port 0 with the response arriving under reset.
    m_silent[0] = 1'b1;
    push(0, 4'(CMD_ADD), 32'd7, 32'd8, w);
    tick(6);
    reset          = 1'b1;
    man_resp[1:0]  = RESP_OK;
    man_data[31:0] = 32'h0000_1234;
    tick(2);
    chk("midrst_req_cmd", req_cmd_out, 0);
    chk("midrst_req_data", req_data_out, 0);
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_spurious", spurious_resp, 0);
    man_resp = '0;
    man_data = '0;
    reset    = 1'b0;
    tick(20);
    chk("postrst_spurious", spurious_resp, 0);
    chk("postrst_req_cmd", req_cmd_out, 0);

    for (int p = 0; p < NP; p++) begin
      chk("final_sb_empty", sb[p].size(), 0);
      chk("final_issue_empty", iq[p].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
